seg_i2c_target: RTL and testbench
=================================

# seg_i2c_target

I2C write-only target (slave) that terminates the serial link driven by the seven-segment display controller. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs accepted bytes and assembles the 16-bit display word. Sits on the display board side, feeding the digit scanner with `disp_data_o`.

## Interface
Parameters:
- `TARGET_ADDR`, 7'h70: 7-bit address this target answers to.
- `MAX_BYTES`, 2: data bytes accepted per transaction; byte index ≥ MAX_BYTES is NACKed.
- `FILTER_LEN`, 3: consecutive equal samples required before a synchronized SCL/SDA level is accepted (glitch filter, ≥1).

Ports:
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `scl_i`  in  1  I2C clock from the bus (asynchronous).
- `sda_in`  in  1  I2C data sampled from the bus (asynchronous).
- `sda_out_en`  out  1  1 = drive SDA (used only for ACK).
- `sda_out`  out  1  value driven when enabled; constant 0 (open-drain).
- `disp_data_o`  out  16  last committed display word; `{byte0, byte1}`, byte0 = high byte.
- `disp_valid_o`  out  1  one-cycle pulse when `disp_data_o` updates.
- `busy_o`  out  1  1 from addressed START until STOP or abandon.
- `err_o`  out  1  sticky: transaction ended with fewer than MAX_BYTES bytes; cleared by next committed word or reset.

## Operation
- Input path: 2-FF synchronizer per line, then FILTER_LEN-sample filter; edges derived from filtered levels.
- START: filtered SDA falls while SCL high. STOP: SDA rises while SCL high. Repeated START restarts from ADDR from any state.
- Bits sampled on filtered SCL rising edge, MSB first; shift register and bit counter (0..7).
- States: IDLE → (START) ADDR → ADDR_ACK → DATA → DATA_ACK → DATA …; IGNORE; STOP from any state → IDLE.
- ADDR: after 8 bits, compare [7:1] with TARGET_ADDR and R/W bit [0]. Match with R/W=0 → ADDR_ACK; otherwise → IGNORE (no ACK, SDA released).
- ACK drive: on SCL falling edge after 8th bit, set `sda_out_en`=1; on next SCL falling edge clear it. In ADDR_ACK/DATA_ACK state advance on that second falling edge.
- DATA: received byte stored in byte buffer at index `byte_cnt`; if `byte_cnt` < MAX_BYTES → ACK and increment; else NACK (no drive) → IGNORE.
- Commit on STOP or repeated START: if `byte_cnt` == MAX_BYTES, `disp_data_o` ← buffer, `disp_valid_o` pulse, `err_o` ← 0. If addressed but 0 < count < MAX_BYTES or count = 0 → no update, `err_o` ← 1. IGNORE (not addressed) never touches outputs.
- `busy_o` = 1 in ADDR_ACK, DATA, DATA_ACK.

## Timing
- Reset values: `sda_out_en`=0, `sda_out`=0, `disp_data_o`=16'h0000, `disp_valid_o`=0, `busy_o`=0, `err_o`=0; state IDLE, counters 0, filters preset to 1 (idle bus).
- Input latency: 2 (sync) + FILTER_LEN cycles from pin to filtered edge.
- `sda_out_en` asserts 1 cycle after the detected SCL falling edge; released 1 cycle after the next falling edge; never changes while filtered SCL is high.
- `disp_valid_o`: exactly one cycle, 1 cycle after STOP detection; `disp_data_o` stable from that cycle.
- Required SCL high/low ≥ 2·(FILTER_LEN+2) clk_i cycles; slower buses are fine, faster ones are unsupported.
- Reset mid-transaction: immediate return to IDLE, ACK released same cycle, buffer discarded, no commit.
- START and STOP in same filtered sample impossible; SDA change while SCL high outside STOP/START treated per above rules (abort to IDLE/ADDR).

## Test plan
- Write 0x70(W), 0x12, 0x34, STOP → both bytes and address ACKed; `disp_data_o`=16'h1234, single `disp_valid_o` pulse, `err_o`=0.
- Address 0x21(W), 0xAA, 0xBB → no ACK on any byte, `sda_out_en` never 1, `disp_data_o` unchanged, `busy_o`=0.
- 0x70(W), 0x12, 0x34, 0x56 → third byte NACKed; at STOP `disp_data_o`=16'h1234.
- 0x70(W), 0x99, STOP → `err_o`=1, no valid pulse; then full 0xAB,0xCD → 16'hABCD, `err_o`=0.
- 0x70(R) → address NACKed, IGNORE until STOP; 0x70(W),0x12, repeated START, 0x70(W),0x56,0x78,STOP → first commit skipped (`err_o`=1), then 16'h5678.
- Assert `rst_i` during ACK of byte0 → `sda_out_en`=0 next cycle, outputs at reset values; 1-cycle SCL glitch with FILTER_LEN=3 → no bit sampled.

Source files
------------

// File: rtl/seg_i2c_target.sv
// Write-only I2C target for the seven-segment display link: oversampled and
// filtered SCL/SDA, 7-bit address match, ACK generation and 16-bit word assembly.
module seg_i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h70,
  parameter int         MAX_BYTES   = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_in,
  output logic        sda_out_en,
  output logic        sda_out,
  output logic [15:0] disp_data_o,
  output logic        disp_valid_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int BCNT_W = $clog2(MAX_BYTES + 1);
  localparam int BUF_W  = (MAX_BYTES < 2) ? 16 : 8 * MAX_BYTES;
  localparam logic [FCNT_W-1:0] FLT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [BCNT_W-1:0] CNT_FULL = BCNT_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic scl_p0, scl_p1, sda_p0, sda_p1;
  logic scl_f_p2, sda_f_p2, scl_f_p3, sda_f_p3;
  logic [FCNT_W-1:0] scl_cnt, sda_cnt;

  logic [6:0]        shift_q;
  logic [7:0]        rx_byte;
  logic [2:0]        bit_cnt;
  logic [BCNT_W-1:0] byte_cnt;
  logic [BUF_W-1:0]  byte_buf;
  logic              addressed;

  logic scl_rise, scl_fall, start_det, stop_det;
  logic ack_nxt, shift_en, store, commit_ok, commit_err, set_addr, clr_txn;

  // Stage p0/p1: two-flop synchronizers; idle bus level is high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      sda_p0 <= sda_in;
      sda_p1 <= sda_p0;
    end
  end

  // Stage p2: level accepted only after FILTER_LEN consecutive disagreeing samples; p3 holds the previous level for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_f_p2 <= 1'b1;
      sda_f_p2 <= 1'b1;
      scl_f_p3 <= 1'b1;
      sda_f_p3 <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      if (scl_p1 == scl_f_p2) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FLT_LAST) begin
        scl_f_p2 <= scl_p1;
        scl_cnt  <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_p1 == sda_f_p2) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FLT_LAST) begin
        sda_f_p2 <= sda_p1;
        sda_cnt  <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
      scl_f_p3 <= scl_f_p2;
      sda_f_p3 <= sda_f_p2;
    end
  end

  assign scl_rise  = scl_f_p2 & ~scl_f_p3;
  assign scl_fall  = ~scl_f_p2 & scl_f_p3;
  assign start_det = scl_f_p2 & scl_f_p3 & sda_f_p3 & ~sda_f_p2;
  assign stop_det  = scl_f_p2 & scl_f_p3 & ~sda_f_p3 & sda_f_p2;
  assign rx_byte   = {shift_q, sda_f_p2};

  always_comb begin
    state_nxt  = state;
    ack_nxt    = sda_out_en;
    shift_en   = 1'b0;
    store      = 1'b0;
    commit_ok  = 1'b0;
    commit_err = 1'b0;
    set_addr   = 1'b0;
    clr_txn    = 1'b0;
    if (start_det || stop_det) begin
      ack_nxt    = 1'b0;
      clr_txn    = 1'b1;
      commit_ok  = addressed && (byte_cnt == CNT_FULL);
      commit_err = addressed && (byte_cnt != CNT_FULL);
      state_nxt  = start_det ? S_ADDR : S_IDLE;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise) begin
            shift_en = 1'b1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == TARGET_ADDR && !rx_byte[0]) begin
                set_addr  = 1'b1;
                state_nxt = S_ADDR_ACK;
              end else begin
                state_nxt = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          // First falling edge grabs SDA, the one after the ACK clock releases it
          if (scl_fall) begin
            if (!sda_out_en) begin
              ack_nxt = 1'b1;
            end else begin
              ack_nxt   = 1'b0;
              state_nxt = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (scl_rise) begin
            shift_en = 1'b1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt < CNT_FULL) begin
                store     = 1'b1;
                state_nxt = S_DATA_ACK;
              end else begin
                state_nxt = S_IGNORE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      sda_out_en   <= 1'b0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      addressed    <= 1'b0;
      disp_valid_o <= 1'b0;
      disp_data_o  <= 16'h0000;
      err_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      sda_out_en   <= ack_nxt;
      disp_valid_o <= commit_ok;
      if (clr_txn)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (clr_txn)       byte_cnt <= '0;
      else if (store)    byte_cnt <= byte_cnt + 1'b1;
      if (clr_txn)       addressed <= 1'b0;
      else if (set_addr) addressed <= 1'b1;
      if (commit_ok) begin
        disp_data_o <= byte_buf[BUF_W-1 -: 16];
        err_o       <= 1'b0;
      end else if (commit_err) begin
        err_o <= 1'b1;
      end
    end
  end

  // Receive shift register and byte buffer: first byte ends up in the top bits
  always_ff @(posedge clk_i) begin
    if (shift_en) shift_q <= rx_byte[6:0];
    if (store)    byte_buf <= {byte_buf[BUF_W-9:0], rx_byte};
  end

  assign sda_out = 1'b0;
  assign busy_o  = (state == S_ADDR_ACK) || (state == S_DATA) || (state == S_DATA_ACK);

endmodule

// File: tb/tb_seg_i2c_target.sv
// Bench for seg_i2c_target: bit-banged I2C master on a wired-AND SDA line and a
// transaction-level reference model of ACKs and committed display words.
module tb_seg_i2c_target;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_line;
  logic        sda_out_en, sda_out;
  logic [15:0] disp_data_o;
  logic        disp_valid_o, busy_o, err_o;

  int n_vec = 0;
  int n_err = 0;

  int vld_seen = 0, vld_wide = 0, en_hi = 0, en_chg_hi = 0;
  logic vld_prev = 1'b0, en_prev = 1'b0;

  logic [15:0] exp_data = 16'h0000;
  logic        exp_err = 1'b0;
  int          exp_vld = 0;
  bit          in_txn = 0;
  bit          cur_ok = 0;
  int          cur_nd = 0;
  logic [7:0]  cur_d0, cur_d1;
  logic [7:0]  tx_d [0:3];
  bit          busy_at_ack;

  always #5 clk = ~clk;

  assign sda_line = m_sda & (sda_out_en ? sda_out : 1'b1);

  seg_i2c_target #(.TARGET_ADDR(7'h70), .MAX_BYTES(2), .FILTER_LEN(3)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(m_scl), .sda_in(sda_line),
    .sda_out_en(sda_out_en), .sda_out(sda_out), .disp_data_o(disp_data_o),
    .disp_valid_o(disp_valid_o), .busy_o(busy_o), .err_o(err_o)
  );

  always @(negedge clk) begin
    if (disp_valid_o) vld_seen <= vld_seen + 1;
    if (disp_valid_o && vld_prev) vld_wide <= vld_wide + 1;
    if (sda_out_en) en_hi <= en_hi + 1;
    if ((sda_out_en != en_prev) && m_scl) en_chg_hi <= en_chg_hi + 1;
    vld_prev <= disp_valid_o;
    en_prev  <= sda_out_en;
  end

  initial begin
    #(800000);
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (m_scl == 1'b0) begin
      m_sda = 1'b1; wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
    end
    m_sda = 1'b0; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_sda = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input bit glitch);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i];
      if (glitch && i == 3) begin
        wait_clk(Q / 2); m_scl = 1'b1; wait_clk(1); m_scl = 1'b0; wait_clk(Q - Q / 2 - 1);
      end else begin
        wait_clk(Q);
      end
      m_scl = 1'b1;
      if (glitch && i == 3) begin
        wait_clk(Q); m_sda = ~b[i]; wait_clk(1); m_sda = b[i]; wait_clk(Q - 1);
      end else begin
        wait_clk(2 * Q);
      end
      m_scl = 1'b0; wait_clk(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output bit ack);
    send_bits(b, glitch);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    ack = ~sda_line;
    busy_at_ack = busy_o;
    wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic model_end();
    if (cur_ok) begin
      if (cur_nd >= 2) begin
        exp_data = {cur_d0, cur_d1};
        exp_err  = 1'b0;
        exp_vld++;
      end else begin
        exp_err = 1'b1;
      end
    end
    cur_ok = 0;
  endtask

  task automatic end_check(input string tag);
    n_vec++;
    if (disp_data_o !== exp_data) begin
      n_err++; $display("FAIL %s disp_data: got %h, expected %h", tag, disp_data_o, exp_data);
    end
    n_vec++;
    if (err_o !== exp_err) begin
      n_err++; $display("FAIL %s err: got %b, expected %b", tag, err_o, exp_err);
    end
    n_vec++;
    if (vld_seen != exp_vld) begin
      n_err++; $display("FAIL %s valid_pulses: got %0d, expected %0d", tag, vld_seen, exp_vld);
    end
  endtask

  task automatic do_txn(input logic [7:0] abyte, input int nd, input bit end_stop,
                        input bit glitch);
    bit ack;
    bit addr_ok;
    bit exp_ack;
    i2c_start();
    if (in_txn) begin
      model_end();
      end_check("rstart");
    end
    in_txn  = 1;
    addr_ok = (abyte[7:1] == 7'h70) && !abyte[0];
    cur_ok  = addr_ok;
    cur_nd  = nd;
    cur_d0  = tx_d[0];
    cur_d1  = tx_d[1];
    send_byte(abyte, 1'b0, ack);
    n_vec++;
    if (ack !== addr_ok) begin
      n_err++; $display("FAIL addr_ack %h: got %b, expected %b", abyte, ack, addr_ok);
    end
    n_vec++;
    if (busy_at_ack !== addr_ok) begin
      n_err++; $display("FAIL busy %h: got %b, expected %b", abyte, busy_at_ack, addr_ok);
    end
    for (int k = 0; k < nd; k++) begin
      send_byte(tx_d[k], glitch && (k == 0), ack);
      exp_ack = addr_ok && (k < 2);
      n_vec++;
      if (ack !== exp_ack) begin
        n_err++; $display("FAIL data_ack[%0d] %h: got %b, expected %b", k, tx_d[k], ack, exp_ack);
      end
    end
    if (end_stop) begin
      i2c_stop();
      model_end();
      in_txn = 0;
      end_check("stop");
      n_vec++;
      if (busy_o !== 1'b0) begin
        n_err++; $display("FAIL busy_after_stop: got %b, expected 0", busy_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clk(5);
    n_vec++; if (sda_out_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b, expected 0", sda_out_en); end
    n_vec++; if (sda_out !== 1'b0) begin n_err++; $display("FAIL rst_sda_out: got %b, expected 0", sda_out); end
    n_vec++; if (disp_data_o !== 16'h0000) begin n_err++; $display("FAIL rst_data: got %h, expected 0000", disp_data_o); end
    n_vec++; if (disp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, expected 0", disp_valid_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, expected 0", busy_o); end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b, expected 0", err_o); end
    rst = 1'b0; wait_clk(10);
  endtask

  task automatic test_basic();
    tx_d[0] = 8'h12; tx_d[1] = 8'h34;
    do_txn(8'hE0, 2, 1'b1, 1'b0);
  endtask

  task automatic test_wrong_addr();
    int en_before;
    en_before = en_hi;
    tx_d[0] = 8'hAA; tx_d[1] = 8'hBB;
    do_txn(8'h42, 2, 1'b1, 1'b0);
    n_vec++;
    if (en_hi != en_before) begin
      n_err++; $display("FAIL wrong_addr_drive: got %0d cycles, expected 0", en_hi - en_before);
    end
  endtask

  task automatic test_overflow();
    tx_d[0] = 8'h12; tx_d[1] = 8'h34; tx_d[2] = 8'h56;
    do_txn(8'hE0, 3, 1'b1, 1'b0);
  endtask

  task automatic test_short();
    tx_d[0] = 8'h99;
    do_txn(8'hE0, 1, 1'b1, 1'b0);
    tx_d[0] = 8'hAB; tx_d[1] = 8'hCD;
    do_txn(8'hE0, 2, 1'b1, 1'b0);
  endtask

  task automatic test_read_restart();
    tx_d[0] = 8'h11;
    do_txn(8'hE1, 1, 1'b1, 1'b0);
    tx_d[0] = 8'h12;
    do_txn(8'hE0, 1, 1'b0, 1'b0);
    tx_d[0] = 8'h56; tx_d[1] = 8'h78;
    do_txn(8'hE0, 2, 1'b1, 1'b0);
  endtask

  task automatic test_glitch();
    tx_d[0] = 8'h5A; tx_d[1] = 8'hC3;
    do_txn(8'hE0, 2, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] a;
    int kind, nd;
    bit stp;
    for (int t = 0; t < 10; t++) begin
      kind = int'($urandom_range(0, 5));
      if (kind <= 3)      a = 8'hE0;
      else if (kind == 4) a = 8'hE1;
      else begin
        a = 8'($urandom);
        if (a[7:1] == 7'h70) a[7] = 1'b0;
      end
      nd = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) tx_d[k] = 8'($urandom);
      stp = (t == 9) ? 1'b1 : 1'($urandom);
      do_txn(a, nd, stp, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    bit ack;
    int waited;
    tx_d[0] = 8'h12; tx_d[1] = 8'h34;
    do_txn(8'hE0, 2, 1'b1, 1'b0);
    i2c_start();
    send_byte(8'hE0, 1'b0, ack);
    send_bits(8'h12, 1'b0);
    m_sda = 1'b1;
    waited = 0;
    while (sda_out_en !== 1'b1 && waited < 4 * Q) begin
      wait_clk(1); waited++;
    end
    n_vec++;
    if (sda_out_en !== 1'b1) begin
      n_err++; $display("FAIL byte0_ack_drive: got %b, expected 1", sda_out_en);
    end
    rst = 1'b1;
    wait_clk(1);
    n_vec++; if (sda_out_en !== 1'b0) begin n_err++; $display("FAIL midrst_en: got %b, expected 0", sda_out_en); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, expected 0", busy_o); end
    n_vec++; if (disp_data_o !== 16'h0000) begin n_err++; $display("FAIL midrst_data: got %h, expected 0000", disp_data_o); end
    wait_clk(2);
    rst = 1'b0;
    exp_data = 16'h0000; exp_err = 1'b0; in_txn = 0; cur_ok = 0;
    m_scl = 1'b1; wait_clk(2 * Q);
    end_check("after_midrst");
    tx_d[0] = 8'hBE; tx_d[1] = 8'hEF;
    do_txn(8'hE0, 2, 1'b1, 1'b0);
  endtask

  task automatic test_monitors();
    n_vec++;
    if (vld_wide != 0) begin
      n_err++; $display("FAIL valid_width: got %0d long pulses, expected 0", vld_wide);
    end
    n_vec++;
    if (en_chg_hi != 0) begin
      n_err++; $display("FAIL ack_change_scl_high: got %0d, expected 0", en_chg_hi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrong_addr();
    test_overflow();
    test_short();
    test_read_restart();
    test_glitch();
    test_random();
    test_reset_mid();
    test_monitors();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
